// File: rtl/fpu_pkg.sv
// Shared encodings for the RV32F control sequencer: opcodes, ALU op codes,
// destination-select codes, FSM states and the decoded-instruction record.
package fpu_pkg;

  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;

  localparam logic [3:0] ALU_FADD     = 4'd0;
  localparam logic [3:0] ALU_FSUB     = 4'd1;
  localparam logic [3:0] ALU_FMUL     = 4'd2;
  localparam logic [3:0] ALU_FDIV     = 4'd3;
  localparam logic [3:0] ALU_FSQRT    = 4'd4;
  localparam logic [3:0] ALU_FSGNJ    = 4'd5;
  localparam logic [3:0] ALU_FSGNJN   = 4'd6;
  localparam logic [3:0] ALU_FSGNJX   = 4'd7;
  localparam logic [3:0] ALU_FMIN     = 4'd8;
  localparam logic [3:0] ALU_FMAX     = 4'd9;
  localparam logic [3:0] ALU_FEQ      = 4'd10;
  localparam logic [3:0] ALU_FLT      = 4'd11;
  localparam logic [3:0] ALU_FLE      = 4'd12;
  localparam logic [3:0] ALU_FCVT_W_S = 4'd13;
  localparam logic [3:0] ALU_FCVT_S_W = 4'd14;
  localparam logic [3:0] ALU_FMV      = 4'd15;

  localparam logic [1:0] FDS_ALU = 2'd0;
  localparam logic [1:0] FDS_MEM = 2'd1;
  localparam logic [1:0] FDS_RS1 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_LDWAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       fp_we;
    logic       int_we;
    logic       fp_2reg_sel;
    logic       in1_sel;
    logic [1:0] fds_sel;
    logic       multicycle;
    logic       is_load;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/fpu_decode.sv
// Combinational RV32F decoder: instruction word -> ALU op, selects, write
// flags, multi-cycle/load markers and the illegal flag for OP-FP.
import fpu_pkg::*;

module fpu_decode (
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0] opcode_s;
  logic [6:0] funct7_s;
  logic [2:0] funct3_s;
  logic [4:0] rs2_s;
  logic       unused_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign rs2_s    = instr[24:20];
  assign funct7_s = instr[31:25];
  assign unused_s = ^{instr[19:15], instr[11:7]};

  function automatic dec_t fp_dst(input logic [3:0] op);
    dec_t d;
    d        = '0;
    d.alu_op = op;
    d.fp_we  = 1'b1;
    return d;
  endfunction

  function automatic dec_t int_dst(input logic [3:0] op, input logic sel);
    dec_t d;
    d             = '0;
    d.alu_op      = op;
    d.int_we      = 1'b1;
    d.fp_2reg_sel = sel;
    return d;
  endfunction

  function automatic dec_t multi(input logic [3:0] op);
    dec_t d;
    d            = '0;
    d.alu_op     = op;
    d.multicycle = 1'b1;
    return d;
  endfunction

  function automatic dec_t bad();
    dec_t d;
    d         = '0;
    d.illegal = 1'b1;
    return d;
  endfunction

  // Field decode; any unrecognised OP-FP encoding is flagged illegal
  always_comb begin
    dec = '0;
    case (opcode_s)
      OPC_OP_FP: begin
        case (funct7_s)
          7'b0000000: dec = fp_dst(ALU_FADD);
          7'b0000100: dec = fp_dst(ALU_FSUB);
          7'b0001000: dec = fp_dst(ALU_FMUL);
          7'b0001100: dec = multi(ALU_FDIV);
          7'b0101100: begin
            if (rs2_s == 5'd0) dec = multi(ALU_FSQRT);
            else               dec = bad();
          end
          7'b0010000: begin
            case (funct3_s)
              3'b000:  dec = fp_dst(ALU_FSGNJ);
              3'b001:  dec = fp_dst(ALU_FSGNJN);
              3'b010:  dec = fp_dst(ALU_FSGNJX);
              default: dec = bad();
            endcase
          end
          7'b0010100: begin
            case (funct3_s)
              3'b000:  dec = fp_dst(ALU_FMIN);
              3'b001:  dec = fp_dst(ALU_FMAX);
              default: dec = bad();
            endcase
          end
          7'b1010000: begin
            case (funct3_s)
              3'b000:  dec = int_dst(ALU_FLE, 1'b1);
              3'b001:  dec = int_dst(ALU_FLT, 1'b1);
              3'b010:  dec = int_dst(ALU_FEQ, 1'b1);
              default: dec = bad();
            endcase
          end
          // Signed and unsigned conversions share one ALU code
          7'b1100000: begin
            if (rs2_s[4:1] == 4'd0) dec = int_dst(ALU_FCVT_W_S, 1'b1);
            else                    dec = bad();
          end
          7'b1101000: begin
            if (rs2_s[4:1] == 4'd0) begin
              dec         = fp_dst(ALU_FCVT_S_W);
              dec.in1_sel = 1'b1;
            end else begin
              dec = bad();
            end
          end
          7'b1110000: begin
            if (rs2_s == 5'd0 && funct3_s == 3'b000) dec = int_dst(ALU_FMV, 1'b0);
            else                                     dec = bad();
          end
          7'b1111000: begin
            if (rs2_s == 5'd0 && funct3_s == 3'b000) begin
              dec         = fp_dst(ALU_FMV);
              dec.fds_sel = FDS_RS1;
            end else begin
              dec = bad();
            end
          end
          default: dec = bad();
        endcase
      end
      OPC_LOAD_FP: begin
        if (funct3_s == 3'b010) begin
          dec.is_load = 1'b1;
          dec.fds_sel = FDS_MEM;
        end else begin
          dec = '0;
        end
      end
      OPC_STORE_FP: dec = '0;
      default:      dec = '0;
    endcase
  end

endmodule

// File: rtl/fpu_ctrl_seq.sv
// RV32F FP-stage control sequencer: single-cycle ops issue straight from decode,
// FDIV/FSQRT/FLW hold the pipeline via stall until completion, flush or reset.
import fpu_pkg::*;

module fpu_ctrl_seq #(
  parameter int DIV_CYCLES  = 16,
  parameter int SQRT_CYCLES = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  input  logic        flush,
  input  logic        mem_rvalid,
  output logic        FP_reg_we,
  output logic        int_reg_we,
  output logic        fp_2reg_sel,
  output logic        FP_alu_in1_sel,
  output logic [1:0]  FP_reg_fds_sel,
  output logic [3:0]  FP_alu_op,
  output logic        stall,
  output logic        illegal
);

  localparam int MAX_LAT = (DIV_CYCLES > SQRT_CYCLES) ? DIV_CYCLES : SQRT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LAT);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 2);
  localparam logic [CNT_W-1:0] SQRT_LOAD = CNT_W'(SQRT_CYCLES - 2);

  dec_t             dec_s;
  state_e           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       op_r;

  fpu_decode u_decode (
    .instr (instr),
    .dec   (dec_s)
  );

  // Sequencer state, latency countdown and the op held across a stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      op_r    <= ALU_FADD;
    end else if (flush) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (instr_valid && dec_s.multicycle) begin
            op_r    <= dec_s.alu_op;
            cnt_r   <= (dec_s.alu_op == ALU_FSQRT) ? SQRT_LOAD : DIV_LOAD;
            state_r <= ST_EXEC;
          end else if (instr_valid && dec_s.is_load) begin
            op_r    <= dec_s.alu_op;
            state_r <= ST_LDWAIT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          if (cnt_r == '0) state_r <= ST_IDLE;
          else             cnt_r   <= cnt_r - CNT_W'(1);
        end
        ST_LDWAIT: begin
          if (mem_rvalid) state_r <= ST_IDLE;
          else            state_r <= ST_LDWAIT;
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // Output selection: live decode while idle, held op and completion write otherwise
  always_comb begin
    FP_reg_we      = 1'b0;
    int_reg_we     = 1'b0;
    fp_2reg_sel    = 1'b0;
    FP_alu_in1_sel = 1'b0;
    FP_reg_fds_sel = FDS_ALU;
    FP_alu_op      = ALU_FADD;
    stall          = 1'b0;
    illegal        = 1'b0;
    if (rst) begin
      stall = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (instr_valid) begin
            FP_alu_op      = dec_s.alu_op;
            fp_2reg_sel    = dec_s.fp_2reg_sel;
            FP_alu_in1_sel = dec_s.in1_sel;
            FP_reg_fds_sel = dec_s.fds_sel;
            illegal        = dec_s.illegal;
            if (dec_s.multicycle || dec_s.is_load) begin
              stall = !flush;
            end else begin
              FP_reg_we  = dec_s.fp_we && !flush;
              int_reg_we = dec_s.int_we && !flush;
            end
          end else begin
            stall = 1'b0;
          end
        end
        ST_EXEC: begin
          FP_alu_op = op_r;
          if (flush)             stall     = 1'b0;
          else if (cnt_r == '0)  FP_reg_we = 1'b1;
          else                   stall     = 1'b1;
        end
        ST_LDWAIT: begin
          FP_alu_op      = op_r;
          FP_reg_fds_sel = FDS_MEM;
          if (flush)           stall     = 1'b0;
          else if (mem_rvalid) FP_reg_we = 1'b1;
          else                 stall     = 1'b1;
        end
        default: stall = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_ctrl_seq.sv
// Bench for fpu_ctrl_seq: mask/match instruction table model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fpu_ctrl_seq;

  localparam int DIV_LAT  = 16;
  localparam int SQRT_LAT = 20;

  logic        clk = 1'b0;
  logic        rst, instr_valid, flush, mem_rvalid;
  logic [31:0] instr;
  logic        FP_reg_we, int_reg_we, fp_2reg_sel, FP_alu_in1_sel, stall, illegal;
  logic [1:0]  FP_reg_fds_sel;
  logic [3:0]  FP_alu_op;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fpu_ctrl_seq #(.DIV_CYCLES(DIV_LAT), .SQRT_CYCLES(SQRT_LAT)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .flush(flush), .mem_rvalid(mem_rvalid), .FP_reg_we(FP_reg_we),
    .int_reg_we(int_reg_we), .fp_2reg_sel(fp_2reg_sel),
    .FP_alu_in1_sel(FP_alu_in1_sel), .FP_reg_fds_sel(FP_reg_fds_sel),
    .FP_alu_op(FP_alu_op), .stall(stall), .illegal(illegal)
  );

  // kind: 0 single-cycle, 1 FDIV, 2 FSQRT, 3 FLW, 4 FSW
  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    int op, fpwe, intwe, sel2, in1, fds, kind;
  } entry_t;
  entry_t tbl[$];

  function automatic void add(input logic [31:0] mask, input logic [31:0] match,
                              input int op, input int fpwe, input int intwe,
                              input int sel2, input int in1, input int fds, input int kind);
    entry_t e;
    e.mask = mask; e.match = match; e.op = op; e.fpwe = fpwe; e.intwe = intwe;
    e.sel2 = sel2; e.in1 = in1; e.fds = fds; e.kind = kind;
    tbl.push_back(e);
  endfunction

  function automatic int lookup(input logic [31:0] ins);
    for (int i = 0; i < tbl.size(); i++)
      if ((ins & tbl[i].mask) == tbl[i].match) return i;
    return -1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 multi-cycle execute, 2 load wait
  int m_mode = 0, m_left = 0, m_op = 0;
  logic m_stall = 1'b0;
  int e_we, e_iwe, e_stall, e_ill, e_op, e_sel2, e_in1, e_fds;
  bit chk_op, chk_sel, chk_fds;
  int idx;
  entry_t ent;

  always @(negedge clk) begin
    e_we = 0; e_iwe = 0; e_stall = 0; e_ill = 0; e_op = 0; e_sel2 = 0; e_in1 = 0; e_fds = 0;
    chk_op = 0; chk_sel = 0; chk_fds = 0;
    if (rst) begin
      m_mode = 0;
      chk_op = 1; chk_sel = 1;
    end else if (m_mode == 0) begin
      if (instr_valid) begin
        idx = lookup(instr);
        if (idx < 0) begin
          e_ill = (instr[6:0] == 7'h53) ? 1 : 0;
        end else begin
          ent = tbl[idx];
          if (ent.kind == 0) begin
            if (!flush) begin e_we = ent.fpwe; e_iwe = ent.intwe; end
            e_op = ent.op; e_sel2 = ent.sel2; e_in1 = ent.in1; e_fds = ent.fds;
            chk_op = 1; chk_sel = 1;
          end else if (ent.kind == 1 || ent.kind == 2) begin
            e_stall = flush ? 0 : 1;
            e_op = ent.op; chk_op = 1;
            if (!flush) begin
              m_mode = 1; m_op = ent.op;
              m_left = (ent.kind == 1) ? DIV_LAT - 1 : SQRT_LAT - 1;
            end
          end else if (ent.kind == 3) begin
            e_stall = flush ? 0 : 1;
            if (!flush) m_mode = 2;
          end
        end
      end
    end else if (m_mode == 1) begin
      e_op = m_op; chk_op = 1;
      if (flush) m_mode = 0;
      else if (m_left == 1) begin e_we = 1; e_fds = 0; chk_fds = 1; m_mode = 0; end
      else begin e_stall = 1; m_left--; end
    end else begin
      if (flush) m_mode = 0;
      else if (mem_rvalid) begin e_we = 1; e_fds = 1; chk_fds = 1; m_mode = 0; end
      else e_stall = 1;
    end
    chk("m_fp_reg_we", FP_reg_we, e_we);
    chk("m_int_reg_we", int_reg_we, e_iwe);
    chk("m_stall", stall, e_stall);
    chk("m_illegal", illegal, e_ill);
    if (chk_op) chk("m_alu_op", FP_alu_op, e_op);
    if (chk_sel) begin
      chk("m_2reg_sel", fp_2reg_sel, e_sel2);
      chk("m_in1_sel", FP_alu_in1_sel, e_in1);
      chk("m_fds_sel", FP_reg_fds_sel, e_fds);
    end else if (chk_fds) begin
      chk("m_fds_sel", FP_reg_fds_sel, e_fds);
    end
    m_stall = e_stall[0];
  end

  task automatic issue(input logic [31:0] ins);
    @(posedge clk); #1;
    instr = ins; instr_valid = 1'b1; flush = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    instr_valid = 1'b0; flush = 1'b0; mem_rvalid = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    int r, i;
    logic [31:0] x;
    r = $urandom_range(0, 15);
    x = $urandom;
    if (r < 11) begin
      i = $urandom_range(0, tbl.size() - 1);
      x = tbl[i].match | (x & ~tbl[i].mask);
    end else if (r < 14) begin
      x[6:0] = 7'h53;
    end
    return x;
  endfunction

  localparam logic [31:0] I_FADD   = 32'h00208053;
  localparam logic [31:0] I_FDIV   = 32'h18208053;
  localparam logic [31:0] I_FSQRT  = 32'h58008053;
  localparam logic [31:0] I_FLW    = 32'h0000A087;
  localparam logic [31:0] I_FCVTSW = 32'hD0008053;
  localparam logic [31:0] I_FMVXW  = 32'hE0008053;
  localparam logic [31:0] I_FLE    = 32'hA0208053;
  localparam logic [31:0] I_FMVWX  = 32'hF0008053;
  localparam logic [31:0] I_BAD    = 32'hFE008053;

  int stalls, wcyc, wes;

  initial begin
    add(32'hFE00007F, 32'h00000053, 0, 1, 0, 0, 0, 0, 0);
    add(32'hFE00007F, 32'h08000053, 1, 1, 0, 0, 0, 0, 0);
    add(32'hFE00007F, 32'h10000053, 2, 1, 0, 0, 0, 0, 0);
    add(32'hFE00007F, 32'h18000053, 3, 0, 0, 0, 0, 0, 1);
    add(32'hFFF0007F, 32'h58000053, 4, 0, 0, 0, 0, 0, 2);
    add(32'hFE00707F, 32'h20000053, 5, 1, 0, 0, 0, 0, 0);
    add(32'hFE00707F, 32'h20001053, 6, 1, 0, 0, 0, 0, 0);
    add(32'hFE00707F, 32'h20002053, 7, 1, 0, 0, 0, 0, 0);
    add(32'hFE00707F, 32'h28000053, 8, 1, 0, 0, 0, 0, 0);
    add(32'hFE00707F, 32'h28001053, 9, 1, 0, 0, 0, 0, 0);
    add(32'hFE00707F, 32'hA0002053, 10, 0, 1, 1, 0, 0, 0);
    add(32'hFE00707F, 32'hA0001053, 11, 0, 1, 1, 0, 0, 0);
    add(32'hFE00707F, 32'hA0000053, 12, 0, 1, 1, 0, 0, 0);
    add(32'hFFF0007F, 32'hC0000053, 13, 0, 1, 1, 0, 0, 0);
    add(32'hFFF0007F, 32'hC0100053, 13, 0, 1, 1, 0, 0, 0);
    add(32'hFFF0007F, 32'hD0000053, 14, 1, 0, 0, 1, 0, 0);
    add(32'hFFF0007F, 32'hD0100053, 14, 1, 0, 0, 1, 0, 0);
    add(32'hFFF0707F, 32'hE0000053, 15, 0, 1, 0, 0, 0, 0);
    add(32'hFFF0707F, 32'hF0000053, 15, 1, 0, 0, 0, 2, 0);
    add(32'h0000707F, 32'h00002007, 0, 0, 0, 0, 0, 1, 3);
    add(32'h0000707F, 32'h00002027, 0, 0, 0, 0, 0, 0, 4);

    // Reset holds every output low even with a valid instruction present
    rst = 1'b1; instr_valid = 1'b1; instr = I_FADD; flush = 1'b0; mem_rvalid = 1'b0;
    #12;
    chk("rst_we", FP_reg_we, 0);
    chk("rst_stall", stall, 0);
    chk("rst_op", FP_alu_op, 0);
    @(posedge clk); #1;
    rst = 1'b0; instr_valid = 1'b0;

    issue(I_FADD); #2;
    chk("fadd_we", FP_reg_we, 1);
    chk("fadd_op", FP_alu_op, 0);
    chk("fadd_fds", FP_reg_fds_sel, 0);
    chk("fadd_stall", stall, 0);

    issue(I_FDIV); #2;
    stalls = stall; wcyc = 0;
    for (int c = 2; c <= 40 && wcyc == 0; c++) begin
      @(posedge clk); #3;
      if (stall) stalls++;
      if (FP_reg_we) wcyc = c;
    end
    chk("fdiv_stall_cycles", stalls, 15);
    chk("fdiv_write_cycle", wcyc, 16);
    idle_cycle(); #2;
    chk("fdiv_after_stall", stall, 0);
    chk("fdiv_after_we", FP_reg_we, 0);

    issue(I_FLW); #2;
    stalls = stall;
    for (int c = 2; c <= 4; c++) begin
      @(posedge clk); #1;
      mem_rvalid = (c == 4);
      #2;
      if (stall) stalls++;
    end
    chk("flw_stall_cycles", stalls, 3);
    chk("flw_we", FP_reg_we, 1);
    chk("flw_fds", FP_reg_fds_sel, 1);
    idle_cycle(); #2;
    chk("flw_after_stall", stall, 0);

    issue(I_FSQRT); #2;
    wes = FP_reg_we;
    for (int c = 2; c <= 5; c++) begin
      @(posedge clk); #1;
      flush = (c == 5);
      #2;
      wes += FP_reg_we;
      if (c == 4) chk("sqrt_pre_flush_stall", stall, 1);
      if (c == 5) chk("sqrt_flush_stall", stall, 0);
    end
    idle_cycle(); #2;
    chk("sqrt_flush_idle_stall", stall, 0);
    chk("sqrt_flush_no_write", wes + FP_reg_we, 0);

    issue(I_FSQRT); #2;
    wes = FP_reg_we;
    for (int c = 2; c <= SQRT_LAT; c++) begin
      @(posedge clk); #1;
      flush = (c == SQRT_LAT);
      #2;
      wes += FP_reg_we;
      if (c == SQRT_LAT - 1) chk("sqrt_last_stall", stall, 1);
      if (c == SQRT_LAT) chk("sqrt_final_flush_stall", stall, 0);
    end
    idle_cycle(); #2;
    chk("sqrt_final_idle_stall", stall, 0);
    chk("sqrt_final_no_write", wes + FP_reg_we, 0);

    issue(I_FCVTSW); #2;
    chk("fcvtsw_in1", FP_alu_in1_sel, 1);
    chk("fcvtsw_op", FP_alu_op, 14);
    chk("fcvtsw_we", FP_reg_we, 1);
    issue(I_FMVXW); #2;
    chk("fmvxw_sel", fp_2reg_sel, 0);
    chk("fmvxw_iwe", int_reg_we, 1);
    issue(I_FLE); #2;
    chk("fle_op", FP_alu_op, 12);
    chk("fle_sel", fp_2reg_sel, 1);
    chk("fle_iwe", int_reg_we, 1);
    issue(I_FMVWX); #2;
    chk("fmvwx_fds", FP_reg_fds_sel, 2);
    chk("fmvwx_we", FP_reg_we, 1);

    issue(I_FDIV);
    for (int c = 0; c < 3; c++) @(posedge clk);
    #3;
    chk("exec_stall_before_rst", stall, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_stall", stall, 0);
    chk("async_rst_we", FP_reg_we, 0);
    chk("async_rst_op", FP_alu_op, 0);
    @(posedge clk); #1;
    rst = 1'b0; instr_valid = 1'b0;
    @(posedge clk); #3;
    chk("post_rst_stall", stall, 0);

    issue(I_BAD); #2;
    chk("illegal_flag", illegal, 1);
    chk("illegal_we", FP_reg_we, 0);
    chk("illegal_iwe", int_reg_we, 0);
    chk("illegal_stall", stall, 0);
    idle_cycle(); #2;
    chk("illegal_one_cycle", illegal, 0);

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (!m_stall) begin
        instr_valid = ($urandom_range(0, 3) != 0);
        instr       = rand_instr();
      end
      flush      = ($urandom_range(0, 19) == 0);
      mem_rvalid = ($urandom_range(0, 2) == 0);
    end
    idle_cycle();
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
